// File: rtl/arb_rr_hold_if.sv
// Request/grant bundle between N requesters (master) and the arbiter (slave).
// Carries the prio vector only when ARB_PRIO_EN is defined.
interface arb_rr_hold_if #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4
);
  localparam int IW = $clog2(N);
  localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          gnt_vld;
  logic [HW-1:0] hold_cnt;
`ifdef ARB_PRIO_EN
  logic [N-1:0]  prio;

  modport master (output req, output prio, input gnt, input gnt_id, input gnt_vld, input hold_cnt);
  modport slave  (input req, input prio, output gnt, output gnt_id, output gnt_vld, output hold_cnt);
`else
  modport master (output req, input gnt, input gnt_id, input gnt_vld, input hold_cnt);
  modport slave  (input req, output gnt, output gnt_id, output gnt_vld, output hold_cnt);
`endif
endinterface

// File: rtl/arb_rr_hold.sv
// N-way round-robin arbiter with grant hold, bounded burst and fully registered grant outputs.
// Define ARB_PRIO_EN to add a high-priority request class (prio vector in the interface).
//
// state | meaning
// IDLE  | no grant outstanding, outputs cleared (gnt_id keeps last holder)
// GRANT | one requester holds the resource, hold_cnt counts its burst
module arb_rr_hold #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  arb_rr_hold_if.slave  arb
);
  localparam int IW = $clog2(N);
  localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] HOLD_MAX  = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] id_q, id_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic [N-1:0]  cand;
  logic [N-1:0]  others;
  logic [N-1:0]  pool;
  logic [IW-1:0] win;
  logic          take;
  logic          preempt;
  logic          hold_req;
  logic          at_limit;

  // First set bit of v, searching upward from p and wrapping at N-1.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] v, input logic [IW-1:0] p);
    logic [IW-1:0] w;
    logic          found;
    int            j;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(p) + k;
      if (j >= N) j = j - N;
      if (!found && v[j]) begin
        w     = IW'(j);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  // Candidate set: the high-priority class when it is non-empty, else every request.
  always_comb begin : class_sel
    cand    = arb.req;
    preempt = 1'b0;
`ifdef ARB_PRIO_EN
    if (|(arb.req & arb.prio)) begin
      cand    = arb.req & arb.prio;
      preempt = !arb.prio[id_q];
    end
`endif
  end

  assign hold_req = arb.req[id_q];
  assign others   = cand & ~(N'(1) << id_q);
  assign at_limit = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      hold_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      IDLE:    if (|cand) state_d = GRANT;
      GRANT:   if (!hold_req && !(|cand)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : fsm_out
    take   = 1'b0;
    pool   = cand;
    gnt_d  = gnt_q;
    id_d   = id_q;
    hold_d = hold_q;
    ptr_d  = ptr_q;
    case (state_q)
      IDLE: begin
        gnt_d  = '0;
        hold_d = '0;
        if (|cand) take = 1'b1;
      end
      GRANT: begin
        if (preempt || !hold_req) begin
          if (|cand) begin
            take = 1'b1;
          end else begin
            gnt_d  = '0;
            hold_d = '0;
          end
        end else if (!at_limit) begin
          if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
        end else if (|others) begin
          take = 1'b1;
          pool = others;
        end else begin
          hold_d = '0;
        end
      end
      default: begin
        gnt_d  = '0;
        hold_d = '0;
      end
    endcase

    win = rr_pick(pool, ptr_q);
    // Pointer moves only when a new holder is chosen.
    if (take) begin
      gnt_d  = N'(1) << win;
      id_d   = win;
      hold_d = '0;
      ptr_d  = (win == IW'(N - 1)) ? '0 : win + 1'b1;
    end
  end

  assign arb.gnt      = gnt_q;
  assign arb.gnt_id   = id_q;
  assign arb.gnt_vld  = (state_q == GRANT);
  assign arb.hold_cnt = hold_q;

endmodule

// File: tb/tb_arb_rr_hold.sv
// Bench for arb_rr_hold (N=4, MAX_HOLD=4): directed scenarios plus random traffic
// checked cycle by cycle against an integer-level round-robin model.
module tb_arb_rr_hold;
  localparam int N    = 4;
  localparam int MAXH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  // model state: holder index (-1 = idle), cycles held minus one, pointer, last id
  int m_h    = -1;
  int m_cnt  = 0;
  int m_ptr  = 0;
  int m_last = 0;

  arb_rr_hold_if #(.N(N), .MAX_HOLD(MAXH)) bus ();

  arb_rr_hold #(.N(N), .MAX_HOLD(MAXH)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr(input logic [3:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic m_grant(input int w);
    m_h    = w;
    m_cnt  = 0;
    m_ptr  = (w + 1) % N;
    m_last = w;
  endtask

  task automatic m_reset();
    m_h = -1; m_cnt = 0; m_ptr = 0; m_last = 0;
  endtask

  task automatic m_edge(input logic [3:0] r);
    logic [3:0] oth;
    if (m_h < 0) begin
      if (r != 0) m_grant(rr(r, m_ptr));
    end else if (!r[m_h]) begin
      if (r != 0) m_grant(rr(r, m_ptr));
      else begin m_h = -1; m_cnt = 0; end
    end else if (m_cnt < MAXH - 1) begin
      m_cnt++;
    end else begin
      oth = r & ~(4'b0001 << m_h);
      if (oth != 0) m_grant(rr(oth, m_ptr));
      else m_cnt = 0;
    end
  endtask

  task automatic chk_model(input string where);
    chk({where, ".gnt"},     32'(bus.gnt),      (m_h < 0) ? 32'd0 : (32'd1 << m_h));
    chk({where, ".vld"},     32'(bus.gnt_vld),  (m_h < 0) ? 32'd0 : 32'd1);
    chk({where, ".id"},      32'(bus.gnt_id),   32'(m_last));
    chk({where, ".hold"},    32'(bus.hold_cnt), (m_h < 0) ? 32'd0 : 32'(m_cnt));
  endtask

  task automatic chk_zero(input string where);
    chk({where, ".gnt"},  32'(bus.gnt),      32'd0);
    chk({where, ".vld"},  32'(bus.gnt_vld),  32'd0);
    chk({where, ".id"},   32'(bus.gnt_id),   32'd0);
    chk({where, ".hold"}, 32'(bus.hold_cnt), 32'd0);
  endtask

  // Drive req, take one rising edge, update model, compare 1 time unit later.
  task automatic step(input logic [3:0] r, input string where);
    bus.req = r;
    @(posedge clk);
    m_edge(r);
    #1;
    chk_model(where);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    chk_zero("rst_async");
    m_reset();
    @(posedge clk);
    #1;
    chk_zero("rst_held");
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] r;
    bus.req = 4'b1111;
`ifdef ARB_PRIO_EN
    bus.prio = '0;
`endif
    #2;
    chk_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_clk");
    rst = 1'b0;
    m_reset();

    // full load: four cycles each, rotating and wrapping
    for (int c = 0; c < 20; c++) begin
      step(4'b1111, "full");
      chk("full.gnt_fixed",  32'(bus.gnt),      32'd1 << ((c / 4) % 4));
      chk("full.hold_fixed", 32'(bus.hold_cnt), 32'(c % 4));
    end

    // lone requester renews its burst, never drops
    for (int c = 0; c < 10; c++) begin
      step(4'b0100, "lone");
      chk("lone.gnt_fixed", 32'(bus.gnt), 32'h4);
    end

    // early release from holder 0
    rst_pulse();
    step(4'b0001, "early0");
    step(4'b1010, "early1");
    chk("early.no_bubble", 32'(bus.gnt), 32'h2);
    for (int c = 0; c < 9; c++) step(4'b1010, "early");

    // idle keeps pointer after a grant to requester 2
    step(4'b0100, "pre_idle");
    chk("pre_idle.gnt_fixed", 32'(bus.gnt), 32'h4);
    step(4'b0000, "idle");
    chk("idle.id_fixed", 32'(bus.gnt_id), 32'd2);
    step(4'b1111, "after_idle");
    chk("after_idle.gnt_fixed", 32'(bus.gnt), 32'h8);

    // reset in the middle of a burst
    step(4'b0100, "mid0");
    step(4'b0100, "mid1");
    step(4'b0100, "mid2");
    rst_pulse();
    step(4'b1111, "post_rst");
    chk("post_rst.gnt_fixed", 32'(bus.gnt), 32'h1);

    // random traffic with varying density and occasional reset
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0:       r = 4'($urandom);
        1:       r = 4'($urandom) & 4'($urandom);
        2:       r = 4'($urandom) | 4'($urandom);
        default: r = (bus.req != 0 && $urandom_range(0, 3) != 0) ? bus.req : 4'($urandom);
      endcase
      if ($urandom_range(0, 249) == 0) rst_pulse();
      step(r, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // hard stop in case anything stalls the stimulus
  initial begin
    #2000000;
    $display("FAIL timeout: got stalled expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/arb_rr_hold.md
Name: arb_rr_hold

Overview:
- Parametrised round-robin arbiter for N requesters. It is the successor to the 4-way round-robin arbiter.
- Adds:
  - grant hold (lock) while the winner keeps requesting,
  - a bounded burst length with forced rotation,
  - an encoded grant index and a grant-valid flag.
- Sits between N request sources and a shared resource (bus, memory port, FIFO write side). Every grant output is registered.

Parameters:
- N, 4, number of requesters; must be >= 2.
- MAX_HOLD, 4, maximum consecutive cycles one requester may hold the grant while others wait; 0 = unlimited hold.
- IW, $clog2(N), width of the grant index (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  N  request vector; bit i = requester i wants the resource.
- gnt  output  N  registered one-hot grant; all-zero when idle.
- gnt_id  output  IW  registered binary index of the grant holder; holds its last value when idle.
- gnt_vld  output  1  registered; 1 when gnt is non-zero.
- hold_cnt  output  $clog2(MAX_HOLD+1) (min 1)  cycles the current holder has held the grant, minus 1; 0 when idle.

Behaviour:
- Reset (async): gnt=0, gnt_id=0, gnt_vld=0, hold_cnt=0, rotation pointer ptr=0, state=IDLE.
- Decision timing: decisions are made at each rising edge from the req sampled at that edge. A grant appears 1 cycle after req is asserted. There are no combinational paths from req to any output.
- Round-robin search:
  - Search starts at index ptr and wraps modulo N. The first set req bit wins.
  - After a new winner w is chosen, ptr <= (w+1) mod N. Wrap from N-1 to 0 is mandatory.
- IDLE state:
  - req==0: stay in IDLE, outputs stay at 0 (gnt_id keeps its last value).
  - Any req bit set: grant the RR winner, hold_cnt<=0, go to GRANT.
- GRANT state, holder h:
  - req[h]==0: re-arbitrate in the same edge among the current req with no bubble cycle. If req==0, gnt<=0 and go to IDLE.
  - req[h]==1 and (MAX_HOLD==0 or hold_cnt<MAX_HOLD-1): keep h, hold_cnt<=hold_cnt+1. Saturate at the max when MAX_HOLD==0.
  - req[h]==1 and hold_cnt==MAX_HOLD-1 (limit reached):
    - Any other req set: grant the RR winner excluding h, hold_cnt<=0.
    - Otherwise: keep h, hold_cnt<=0 (renewed burst).
- ptr updates only when the holder changes, or on the first grant out of IDLE.
- Exactly one gnt bit is set whenever gnt_vld=1.
- gnt_id always equals the encoded index of gnt when gnt_vld=1.
- Reset asserted mid-grant: outputs clear immediately, without waiting for clk. On the first edge after release, arbitration restarts from ptr=0.

Optional Feature:
- Macro ARB_PRIO_EN.
- When defined:
  - Adds input prio (N bits). Requests with req&prio non-zero form a high-priority class.
  - If the high-priority class is non-empty, RR arbitration (same ptr) runs only over that class.
  - A holder that is not high-priority is pre-empted at the next edge when any high-priority request appears, regardless of hold_cnt.
  - A high-priority holder obeys the normal hold rules within its class.
- When undefined: the prio port does not exist and behaviour is pure round-robin as above.

Test Plan (N=4, MAX_HOLD=4):
- Reset: assert rst with req=4'b1111 → gnt=0, gnt_vld=0, gnt_id=0, hold_cnt=0 while rst is high.
- Full load: release rst, req=4'b1111 constant → gnt=0001 for 4 cycles (hold_cnt 0,1,2,3), then 0010 x4, 0100 x4, 1000 x4, then wraps to 0001.
- Lone requester: req=4'b0100 constant → gnt=0100 every cycle; hold_cnt cycles 0..3 and renews; gnt never drops.
- Early release: gnt=0001 held; req becomes 4'b1010 → next edge gnt=0010 (no idle cycle); after 4 cycles gnt=1000; then 0010 again.
- Idle keeps pointer: last grant was to requester 2, then req=0 → gnt=0, gnt_vld=0, gnt_id=2. Then req=4'b1111 → gnt=1000.
- Reset mid-burst: gnt=0100, hold_cnt=2, pulse rst → outputs 0 immediately; after release with req=4'b1111 → gnt=0001.
- With ARB_PRIO_EN only, as an extra scenario: holder 0 with req=1111, prio=0100 → next edge gnt=0100.
